// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces active-low push keys, producing
// one-cycle press/release events and a registered pressed-key bitmask.
//
// Ports:
//   sys_clk50m  in   system clock, rising edge
//   rst_n       in   asynchronous reset, active low
//   key_in      in   raw key pins, active low (0 = pressed), asynchronous
//   key_valid   out  one-cycle pulse when a press has been debounced
//   key_release out  one-cycle pulse when a full release has been debounced
//   key_code    out  pressed-key bitmask (1 = pressed), updated with key_valid
//   key_held    out  high while a debounced press is in effect
module key_debounce #(
  parameter int NUM_KEYS     = 4,
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CNT = 1000000
) (
  input  logic                sys_clk50m,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                key_valid,
  output logic                key_release,
  output logic [NUM_KEYS-1:0] key_code,
  output logic                key_held
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REL_DB
  } state_t;

  state_t state;
  state_t state_n;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] ksync;
  logic [NUM_KEYS-1:0] snap;
  logic [NUM_KEYS-1:0] snap_n;
  logic [NUM_KEYS-1:0] code_n;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_n;
  logic                valid_n;
  logic                rel_n;
  logic                held_n;
  logic                all_up;

  // Two-flop synchroniser; idle level of the pins is all ones.
  always_ff @(posedge sys_clk50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      ksync <= '1;
    end else begin
      sync1 <= key_in;
      ksync <= sync1;
    end
  end

  assign all_up = &ksync;

  always_ff @(posedge sys_clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      snap        <= '1;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_code    <= '0;
      key_held    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      snap        <= snap_n;
      key_valid   <= valid_n;
      key_release <= rel_n;
      key_code    <= code_n;
      key_held    <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_n  = snap;
    code_n  = key_code;
    valid_n = 1'b0;
    rel_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!all_up) begin
          snap_n  = ksync;
          cnt_n   = '0;
          state_n = PRESS_DB;
        end
      end
      PRESS_DB: begin
        // Any change of the key set restarts detection from IDLE.
        if (ksync != snap) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = PRESSED;
          valid_n = 1'b1;
          code_n  = ~snap;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        // Only a complete release is of interest here.
        if (all_up) begin
          cnt_n   = '0;
          state_n = REL_DB;
        end
      end
      REL_DB: begin
        if (!all_up) begin
          cnt_n   = '0;
          state_n = PRESSED;
        end else if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = IDLE;
          rel_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    held_n = (state_n == PRESSED) ||
             (state_n == REL_DB);
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and random stimulus for key_debounce,
// checked every cycle against a behavioural model of the key rules.
module tb_key_debounce;

  localparam int D = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_release;
  logic [3:0] key_code;
  logic       key_held;

  int tests;
  int fails;
  int nvalid;
  int nrel;

  key_debounce #(
    .NUM_KEYS    (4),
    .CNT_W       (4),
    .DEBOUNCE_CNT(D)
  ) dut (
    .sys_clk50m (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_release(key_release),
    .key_code   (key_code),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a raw pattern reaches the key logic two edges late. A press
  // is accepted when one non-idle pattern is seen D+1 samples in a row
  // from the sample that opened the window; a differing sample closes
  // the window without opening a new one. Once held, a release is
  // accepted after D+1 consecutive all-ones samples.
  logic [3:0] p1, p2, s, win_pat;
  bit         held, win_open;
  int         win_len, run1;
  logic       m_valid, m_rel, m_held;
  logic [3:0] m_code;

  initial begin
    tests = 0;
    fails = 0;
    nvalid = 0;
    nrel = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        p1 = 4'hF;
        p2 = 4'hF;
        held = 0;
        win_open = 0;
        win_len = 0;
        run1 = 0;
        m_valid = 0;
        m_rel = 0;
        m_code = 4'h0;
        m_held = 0;
      end else begin
        s = p2;
        p2 = p1;
        p1 = key_in;
        m_valid = 0;
        m_rel = 0;
        if (!held) begin
          if (win_open) begin
            if (s != win_pat) begin
              win_open = 0;
            end else begin
              win_len++;
              if (win_len == D + 1) begin
                m_valid = 1;
                m_code = ~s;
                held = 1;
                run1 = 0;
                win_open = 0;
              end
            end
          end else if (s != 4'hF) begin
            win_open = 1;
            win_pat = s;
            win_len = 1;
          end
        end else begin
          if (s == 4'hF) begin
            run1++;
            if (run1 == D + 1) begin
              m_rel = 1;
              held = 0;
              win_open = 0;
            end
          end else begin
            run1 = 0;
          end
        end
        m_held = held;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("valid", {31'd0, key_valid}, {31'd0, m_valid});
      chk("release", {31'd0, key_release}, {31'd0, m_rel});
      chk("code", {28'd0, key_code}, {28'd0, m_code});
      chk("held", {31'd0, key_held}, {31'd0, m_held});
      if (key_valid && key_release) begin
        chk("both_pulses", 32'd1, 32'd0);
      end
      if (key_valid) nvalid++;
      if (key_release) nrel++;
    end
  end

  task automatic wait_pulse(input bit rel,
                            input int exp_n,
                            input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #2;
      n++;
      seen = rel ? key_release : key_valid;
    end
    tests++;
    if (!seen || n != exp_n) begin
      fails++;
      $display("FAIL %s: latency %0d seen %0d expected %0d",
               name, n, seen, exp_n);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {26'd0, key_valid, key_release,
               key_code, key_held}, 32'd0);
  endtask

  initial begin
    int v0;
    int r0;
    int len;
    int r;
    rst_n = 1'b0;
    key_in = 4'hF;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press
    v0 = nvalid;
    key_in = 4'b1110;
    wait_pulse(0, 11, "c1_latency");
    chk("c1_code", {28'd0, key_code}, 32'h1);
    chk("c1_held", {31'd0, key_held}, 32'h1);
    repeat (19) @(negedge clk);
    chk("c1_once", nvalid - v0, 32'd1);

    // Release
    key_in = 4'b1111;
    wait_pulse(1, 11, "c3_latency");
    chk("c3_held", {31'd0, key_held}, 32'h0);
    chk("c3_code", {28'd0, key_code}, 32'h1);
    repeat (4) @(negedge clk);

    // Bounce
    v0 = nvalid;
    key_in = 4'b1110;
    repeat (4) @(negedge clk);
    key_in = 4'b1111;
    repeat (2) @(negedge clk);
    key_in = 4'b1110;
    chk("c2_nobounce", nvalid - v0, 32'd0);
    wait_pulse(0, 11, "c2_latency");
    chk("c2_code", {28'd0, key_code}, 32'h1);
    repeat (3) @(negedge clk);

    // Release glitch
    v0 = nvalid;
    r0 = nrel;
    key_in = 4'b1111;
    repeat (5) @(negedge clk);
    key_in = 4'b1110;
    @(negedge clk);
    key_in = 4'b1111;
    chk("c4_no_early_rel", nrel - r0, 32'd0);
    wait_pulse(1, 11, "c4_latency");
    chk("c4_no_valid", nvalid - v0, 32'd0);
    repeat (3) @(negedge clk);

    // Two keys together
    key_in = 4'b1010;
    wait_pulse(0, 11, "c5_latency");
    chk("c5_code", {28'd0, key_code}, 32'h5);
    @(negedge clk);
    v0 = nvalid;
    key_in = 4'b1000;
    repeat (20) @(negedge clk);
    chk("c5_no_new", nvalid - v0, 32'd0);
    chk("c5_code_kept", {28'd0, key_code}, 32'h5);
    key_in = 4'b1111;
    wait_pulse(1, 11, "c5_release");
    repeat (3) @(negedge clk);

    // Reset mid-debounce
    key_in = 4'b1110;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("c6_reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(0, 11, "c6_latency");
    chk("c6_code", {28'd0, key_code}, 32'h1);
    @(negedge clk);
    key_in = 4'b1111;
    wait_pulse(1, 11, "c6_release");
    @(negedge clk);

    // Random stimulus
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 4) key_in = 4'hF;
      else if (r < 6) key_in = key_in;
      else key_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(10, 24);
      else len = $urandom_range(1, 6);
      repeat (len) @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    key_in = 4'hF;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
